// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and latency helpers for the hazard scoreboard unit.
// Optional perf counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_scoreboard_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic stall_ifid;
    logic flush_ifid;
    logic flush_idex;
    logic pc_write;
    logic ir_write;
    logic issue;
  } hz_ctrl_t;

  localparam int RCNT_W = 3;

  localparam hz_ctrl_t CTRL_RUN = '{
    stall_ifid: 1'b0,
    flush_ifid: 1'b0,
    flush_idex: 1'b0,
    pc_write:   1'b1,
    ir_write:   1'b1,
    issue:      1'b0
  };

  function automatic int alu_lat(
    input int df,
    input int wb
  );
    return (df != 0) ? 0 : wb;
  endfunction

  function automatic int load_lat(
    input int df,
    input int wb
  );
    return (df != 0) ? 1 : wb;
  endfunction

  function automatic int max_lat(
    input int df,
    input int wb
  );
    int a;
    int l;
    a = alu_lat(df, wb);
    l = load_lat(df, wb);
    return (l > a) ? l : a;
  endfunction

  // Never narrower than one bit, even with zero latency.
  function automatic int cnt_w(input int lat);
    int w;
    w = 1;
    while ((1 << w) < (lat + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_reg_counter.sv
// One scoreboard entry: countdown to the cycle its
// register value becomes usable by ID.
module hazard_reg_counter
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] lat,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dec;

  assign dec  = (cnt != '0) ? cnt - CNT_W'(1) : '0;
  assign busy = (cnt != '0);

  // A new writer may only extend the entry, never shorten it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (dec > lat) ? dec : lat;
    end else begin
      cnt <= dec;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based hazard controller beside ID.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_REGS        = 4,
  parameter int REG_ADDR_W      = 2,
  parameter int DATA_FORWARDING = 0,
  parameter int WB_DIST         = 3,
  parameter int REDIRECT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_is_load,
  input  logic                  jump_miss,
  input  logic                  branch_miss,
  output logic                  stall_IFID,
  output logic                  flush_IFID,
  output logic                  flush_IDEX,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  issue
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_cycles
`endif
);

  localparam int ALU_LAT  =
    alu_lat(DATA_FORWARDING, WB_DIST);
  localparam int LOAD_LAT =
    load_lat(DATA_FORWARDING, WB_DIST);
  localparam int CNT_W    =
    cnt_w(max_lat(DATA_FORWARDING, WB_DIST));
  localparam int SPAN     = 1 << REG_ADDR_W;

  localparam logic [RCNT_W-1:0] RLOAD =
    RCNT_W'(REDIRECT_CYCLES - 1);
  localparam logic MULTI_REDIR =
    (REDIRECT_CYCLES > 1);

  hz_state_e         state;
  logic [RCNT_W-1:0] rcnt;
  hz_ctrl_t          ctrl;

  logic [SPAN-1:0]  busy;
  logic [CNT_W-1:0] lat_sel;
  logic             data_stall;
  logic             take_br;
  logic             take_jm;
  logic             take_ds;

  assign lat_sel = id_is_load ? CNT_W'(LOAD_LAT)
                              : CNT_W'(ALU_LAT);

  for (genvar r = 0; r < SPAN; r++) begin : g_sb
    if (r < NUM_REGS) begin : g_ent
      logic load;
      assign load = ctrl.issue & id_reg_write &
                    (id_dest == REG_ADDR_W'(r));
      hazard_reg_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .lat     (lat_sel),
        .busy    (busy[r])
      );
    end else begin : g_pad
      assign busy[r] = 1'b0;
    end
  end

  assign data_stall = id_valid &
    ((id_use_rs & busy[id_rs]) |
     (id_use_rt & busy[id_rt]));

  assign take_br = branch_miss;
  assign take_jm = ~branch_miss & jump_miss;
  assign take_ds = ~branch_miss & ~jump_miss &
                   data_stall;

  always_comb begin
    ctrl = CTRL_RUN;
    if (!reset_n) begin
      ctrl = CTRL_RUN;
    end else if (state == REDIRECT) begin
      ctrl.flush_ifid = 1'b1;
      ctrl.flush_idex = 1'b1;
    end else begin
      unique case (1'b1)
        take_br: begin
          ctrl.flush_ifid = 1'b1;
          ctrl.flush_idex = 1'b1;
        end
        take_jm: begin
          ctrl.flush_ifid = 1'b1;
          ctrl.issue      = id_valid;
        end
        take_ds: begin
          ctrl.stall_ifid = 1'b1;
          ctrl.flush_idex = 1'b1;
          ctrl.pc_write   = 1'b0;
          ctrl.ir_write   = 1'b0;
        end
        default: begin
          ctrl.issue = id_valid;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      rcnt  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if ((branch_miss | jump_miss) &
              MULTI_REDIR) begin
            state <= REDIRECT;
            rcnt  <= RLOAD;
          end
        end
        REDIRECT: begin
          if (branch_miss) begin
            rcnt <= RLOAD;
          end else if (rcnt <= RCNT_W'(1)) begin
            state <= RUN;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt - RCNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          rcnt  <= '0;
        end
      endcase
    end
  end

  assign stall_IFID = ctrl.stall_ifid;
  assign flush_IFID = ctrl.flush_ifid;
  assign flush_IDEX = ctrl.flush_idex;
  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign issue      = ctrl.issue;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
    end else begin
      if (data_stall & ~ctrl.flush_ifid)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ctrl.flush_ifid)
        perf_flush_cycles <= perf_flush_cycles + 32'd1;
    end
  end
`else
`endif

endmodule
